// File: rtl/c3lib_and_filt_pkg.sv
// -----------------------------------------------------------------------------
// c3lib_and_filt_pkg
// Shared types and parameter limits for the filtered AND-reduce block.
//   and_filt_st_e : qualification FSM states (IDLE / QUAL / ON)
//   *_MIN / *_MAX : legal ranges checked at elaboration by the top level
// -----------------------------------------------------------------------------
package c3lib_and_filt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    QUAL = 2'd1,
    ON   = 2'd2
  } and_filt_st_e;

  localparam int WIDTH_MIN       = 1;
  localparam int WIDTH_MAX       = 32;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int FILT_CYCLES_MIN = 1;
  localparam int FILT_CYCLES_MAX = 65535;

endpackage

// File: rtl/c3lib_sync_nstg.sv
// -----------------------------------------------------------------------------
// c3lib_sync_nstg
// Single-bit N-stage synchroniser, all stages reset to 0.
//   clk   in  : destination clock
//   rst_n in  : asynchronous active-low reset
//   d     in  : asynchronous data bit
//   q     out : synchronised data (last stage)
// -----------------------------------------------------------------------------
module c3lib_sync_nstg #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stg_r;

  // Shift chain: stage 0 captures the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_r <= '0;
    end else begin
      stg_r <= {stg_r[STAGES-2:0], d};
    end
  end

  assign q = stg_r[STAGES-1];

endmodule

// File: rtl/c3lib_and_reduce_filt.sv
// -----------------------------------------------------------------------------
// c3lib_and_reduce_filt
// N-input AND of asynchronous status bits with per-input synchroniser, mask and
// a debounce filter: deasserts one cycle after the condition is lost, asserts
// only after FILT_CYCLES consecutive true samples.
//   clk        in  : clock, rising edge
//   rst_n      in  : asynchronous active-low reset
//   en         in  : block enable; low forces the filter idle
//   in_async   in  : WIDTH asynchronous status inputs
//   in_mask    in  : WIDTH mask bits, 1 = input ignored (treated as true)
//   in_sync    out : synchronised copy of in_async
//   out        out : filtered AND result (registered)
//   fall_pulse out : one-cycle pulse when out drops because the condition was lost
// -----------------------------------------------------------------------------
module c3lib_and_reduce_filt
  import c3lib_and_filt_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] in_async,
  input  logic [WIDTH-1:0] in_mask,
  output logic [WIDTH-1:0] in_sync,
  output logic             out,
  output logic             fall_pulse
);

  localparam int CW = $clog2(FILT_CYCLES + 1);
  localparam logic [CW-1:0] FILT_LAST = CW'(FILT_CYCLES);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("c3lib_and_reduce_filt: WIDTH %0d out of range", WIDTH);
  end
  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("c3lib_and_reduce_filt: SYNC_STAGES %0d out of range", SYNC_STAGES);
  end
  if (FILT_CYCLES < FILT_CYCLES_MIN || FILT_CYCLES > FILT_CYCLES_MAX) begin : g_bad_filt
    $error("c3lib_and_reduce_filt: FILT_CYCLES %0d out of range", FILT_CYCLES);
  end

  and_filt_st_e  state_r;
  logic [CW-1:0] cnt_r;
  logic          out_r;
  logic          fall_r;
  logic          and_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_sync
    c3lib_sync_nstg #(
      .STAGES(SYNC_STAGES)
    ) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (in_async[i]),
      .q    (in_sync[i])
    );
  end

  // Masked AND; a fully masked vector means nothing is being monitored, so the
  // result is forced false rather than vacuously true.
  always_comb begin
    and_s = 1'b0;
    if (&in_mask) begin
      and_s = 1'b0;
    end else begin
      and_s = &(in_sync | in_mask);
    end
  end

  // Qualification FSM with saturating counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      out_r   <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      fall_r <= 1'b0;
      case (state_r)
        IDLE: begin
          out_r <= 1'b0;
          if (en && and_s) begin
            cnt_r <= CW'(1);
            if (FILT_CYCLES == 1) begin
              state_r <= ON;
              out_r   <= 1'b1;
            end else begin
              state_r <= QUAL;
            end
          end else begin
            cnt_r <= '0;
          end
        end
        QUAL: begin
          if (en && and_s) begin
            if (cnt_r != FILT_LAST) begin
              cnt_r <= cnt_r + CW'(1);
            end
            if (cnt_r + CW'(1) == FILT_LAST) begin
              state_r <= ON;
              out_r   <= 1'b1;
            end
          end else begin
            // Any false sample discards all accumulated credit.
            state_r <= IDLE;
            cnt_r   <= '0;
            out_r   <= 1'b0;
          end
        end
        ON: begin
          if (!en) begin
            // Disable is not a loss of condition: no fall pulse.
            state_r <= IDLE;
            cnt_r   <= '0;
            out_r   <= 1'b0;
          end else if (!and_s) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            out_r   <= 1'b0;
            fall_r  <= 1'b1;
          end else begin
            out_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          out_r   <= 1'b0;
        end
      endcase
    end
  end

  assign out        = out_r;
  assign fall_pulse = fall_r;

endmodule

// File: tb/tb_c3lib_and_reduce_filt.sv
// -----------------------------------------------------------------------------
// tb_c3lib_and_reduce_filt
// Two instances (S=2/F=8 and S=3/F=1) share stimulus. A reference model
// tracks, per instance, the input history and the length of the current run
// of qualifying samples: out is high exactly when that run is >= FILT_CYCLES.
// -----------------------------------------------------------------------------
module tb_c3lib_and_reduce_filt;

  localparam int S_A = 2;
  localparam int F_A = 8;
  localparam int S_B = 3;
  localparam int F_B = 1;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] in_async;
  logic [3:0] in_mask;
  logic [3:0] sync_a, sync_b;
  logic       out_a, out_b;
  logic       fp_a, fp_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int         ss [2] = '{S_A, S_B};
  int         ff [2] = '{F_A, F_B};
  int         run [2];
  logic       mout [2];
  logic       mfall [2];
  logic [3:0] hist [2][4];

  typedef struct {
    logic       en;
    logic [3:0] din;
    logic [3:0] mask;
    int         n;
    logic       e_out_a;
    logic       e_fp_a;
    logic       e_out_b;
    logic       e_fp_b;
    logic [3:0] e_sync_a;
  } vec_t;

  vec_t vecs [9];

  c3lib_and_reduce_filt #(.WIDTH(4), .SYNC_STAGES(S_A), .FILT_CYCLES(F_A)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .in_async(in_async), .in_mask(in_mask),
    .in_sync(sync_a), .out(out_a), .fall_pulse(fp_a)
  );

  c3lib_and_reduce_filt #(.WIDTH(4), .SYNC_STAGES(S_B), .FILT_CYCLES(F_B)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .in_async(in_async), .in_mask(in_mask),
    .in_sync(sync_b), .out(out_b), .fall_pulse(fp_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      run[i]   = 0;
      mout[i]  = 1'b0;
      mfall[i] = 1'b0;
      for (int k = 0; k < 4; k++) hist[i][k] = 4'h0;
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      logic [3:0] seen;
      logic       all_ok;
      seen   = hist[i][ss[i]-1];
      all_ok = (in_mask != 4'hF) && ((seen | in_mask) == 4'hF);
      mfall[i] = mout[i] && en && !all_ok;
      if (en && all_ok) begin
        if (run[i] < 100000) run[i] = run[i] + 1;
      end else begin
        run[i] = 0;
      end
      mout[i] = (run[i] >= ff[i]);
      for (int k = 3; k > 0; k--) hist[i][k] = hist[i][k-1];
      hist[i][0] = in_async;
    end
  endtask

  // One clock: model update at the edge, DUT compared 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("out_a",  {31'd0, out_a}, {31'd0, mout[0]});
    check("fall_a", {31'd0, fp_a},  {31'd0, mfall[0]});
    check("sync_a", {28'd0, sync_a}, {28'd0, hist[0][S_A-1]});
    check("out_b",  {31'd0, out_b}, {31'd0, mout[1]});
    check("fall_b", {31'd0, fp_b},  {31'd0, mfall[1]});
    check("sync_b", {28'd0, sync_b}, {28'd0, hist[1][S_B-1]});
  endtask

  // Asynchronous reset pulse placed mid-cycle; outputs must clear immediately.
  task automatic reset_pulse(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    check({tag, "_out_a"},  {31'd0, out_a}, 32'd0);
    check({tag, "_fall_a"}, {31'd0, fp_a},  32'd0);
    check({tag, "_sync_a"}, {28'd0, sync_a}, 32'd0);
    check({tag, "_out_b"},  {31'd0, out_b}, 32'd0);
    check({tag, "_sync_b"}, {28'd0, sync_b}, 32'd0);
    model_reset();
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // en, din, mask, n, out_a, fp_a, out_b, fp_b, sync_a
    vecs[0] = '{1'b1, 4'hF, 4'h0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 4'hF};
    vecs[1] = '{1'b1, 4'hF, 4'h0, 2, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF};
    vecs[2] = '{1'b1, 4'hF, 4'h0, 5, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF};
    vecs[3] = '{1'b1, 4'hF, 4'h0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF};
    vecs[4] = '{1'b1, 4'hB, 4'h0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF};
    vecs[5] = '{1'b1, 4'hF, 4'h0, 2, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF};
    vecs[6] = '{1'b1, 4'hF, 4'h0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 4'hF};
    vecs[7] = '{1'b1, 4'hF, 4'h0, 6, 1'b0, 1'b0, 1'b1, 1'b0, 4'hF};
    vecs[8] = '{1'b1, 4'hF, 4'h0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF};

    en       = 1'b0;
    in_async = 4'h0;
    in_mask  = 4'h0;
    rst_n    = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_a",  {31'd0, out_a}, 32'd0);
    check("rst_fall_a", {31'd0, fp_a},  32'd0);
    check("rst_sync_a", {28'd0, sync_a}, 32'd0);
    check("rst_out_b",  {31'd0, out_b}, 32'd0);
    check("rst_cnt_a",  {28'd0, u_a.cnt_r}, 32'd0);
    rst_n = 1'b1;

    // Table: rise, 1-cycle glitch on in[2], recovery.
    for (int v = 0; v < 9; v++) begin
      en       = vecs[v].en;
      in_async = vecs[v].din;
      in_mask  = vecs[v].mask;
      repeat (vecs[v].n) tick();
      check("vec_out_a",  {31'd0, out_a}, {31'd0, vecs[v].e_out_a});
      check("vec_fall_a", {31'd0, fp_a},  {31'd0, vecs[v].e_fp_a});
      check("vec_out_b",  {31'd0, out_b}, {31'd0, vecs[v].e_out_b});
      check("vec_fall_b", {31'd0, fp_b},  {31'd0, vecs[v].e_fp_b});
      check("vec_sync_a", {28'd0, sync_a}, {28'd0, vecs[v].e_sync_a});
    end

    // en falls while ON: no fall pulse.
    en = 1'b0;
    tick();
    check("endrop_out_a",  {31'd0, out_a}, 32'd0);
    check("endrop_fall_a", {31'd0, fp_a},  32'd0);
    check("endrop_fall_b", {31'd0, fp_b},  32'd0);
    en = 1'b1;

    // Masked false input, then unmask while ON.
    in_async = 4'b1011;
    in_mask  = 4'b0100;
    repeat (12) tick();
    check("mask_on_a", {31'd0, out_a}, 32'd1);
    in_mask = 4'b0000;
    tick();
    check("unmask_out_a",  {31'd0, out_a}, 32'd0);
    check("unmask_fall_a", {31'd0, fp_a},  32'd1);
    check("unmask_fall_b", {31'd0, fp_b},  32'd1);

    // Everything masked: never asserts.
    in_async = 4'hF;
    in_mask  = 4'hF;
    repeat (12) tick();
    check("allmask_out_a", {31'd0, out_a}, 32'd0);
    check("allmask_out_b", {31'd0, out_b}, 32'd0);

    // en and and_s fall in the same cycle: en wins, no pulse.
    in_async = 4'b1011;
    in_mask  = 4'b0100;
    repeat (12) tick();
    check("both_pre_a", {31'd0, out_a}, 32'd1);
    en      = 1'b0;
    in_mask = 4'b0000;
    tick();
    check("both_out_a",  {31'd0, out_a}, 32'd0);
    check("both_fall_a", {31'd0, fp_a},  32'd0);
    check("both_fall_b", {31'd0, fp_b},  32'd0);
    en = 1'b1;

    // in[0] toggling every 5 cycles never qualifies with F=8.
    in_async = 4'b1110;
    for (int t = 0; t < 6; t++) begin
      in_async[0] = ~in_async[0];
      repeat (5) begin
        tick();
        check("toggle_out_a", {31'd0, out_a}, 32'd0);
        check("toggle_cnt_le5", {31'd0, (u_a.cnt_r <= 4'd5)}, 32'd1);
      end
    end

    // Reset mid-QUAL, reset mid-ON, then F=1 latency from reset.
    in_async = 4'hF;
    repeat (4) tick();
    reset_pulse("rst_qual");
    repeat (12) tick();
    check("rst_pre_on_a", {31'd0, out_a}, 32'd1);
    reset_pulse("rst_on");
    repeat (S_B) tick();
    check("f1_early_b", {31'd0, out_b}, 32'd0);
    tick();
    check("f1_on_b", {31'd0, out_b}, 32'd1);

    // Randomised segments against the model.
    for (int seg = 0; seg < 80; seg++) begin
      logic [3:0] d;
      logic [3:0] m;
      for (int b = 0; b < 4; b++) begin
        d[b] = ($urandom_range(0, 7) != 0);
        m[b] = ($urandom_range(0, 9) == 0);
      end
      en       = ($urandom_range(0, 9) != 0);
      in_async = d;
      in_mask  = m;
      repeat ($urandom_range(1, 12)) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
